multi_cycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit aluOp that the ALU-control decoder consumes, using the encoding 00 add, 01 sub, 10 use funct, 11 addi.
- Honours a memory-ready handshake, so instruction and data memory may insert wait states.

---
 rtl/multi_cycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Function : Main control FSM for a multi-cycle MIPS datapath with a
//            memory-ready handshake. Optional macro ILLEGAL_OP_TRAP_EN makes
//            undefined opcodes enter a sticky TRAP state and adds illegalOp.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic [1:0]         pcSource,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic               instrDone,
    output logic [STATE_W-1:0] state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic               illegalOp
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STATE_W'(S_IDLE);
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next_state = r_state;
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        pcSource     = 2'b00;
        iorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        memToReg     = 1'b0;
        regDst       = 1'b0;
        regWrite     = 1'b0;
        aluSrcA      = 1'b0;
        aluSrcB      = 2'b00;
        aluOp        = 2'b00;
        instrDone    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        illegalOp    = 1'b0;
`endif
        case (r_state)
            STATE_W'(S_IDLE): begin
                w_next_state = STATE_W'(S_FETCH);
            end
            STATE_W'(S_FETCH): begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) begin
                    w_next_state = STATE_W'(S_DECODE);
                end
            end
            STATE_W'(S_DECODE): begin
                // PC + (imm << 2) is computed here for a possible beq
                aluSrcB = 2'b11;
                case (opcode)
                    C_OP_LW, C_OP_SW: w_next_state = STATE_W'(S_MEM_ADDR);
                    C_OP_RTYPE:       w_next_state = STATE_W'(S_EXEC);
                    C_OP_BEQ:         w_next_state = STATE_W'(S_BRANCH);
                    C_OP_ADDI:        w_next_state = STATE_W'(S_ADDI_EX);
                    C_OP_J:           w_next_state = STATE_W'(S_JUMP);
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_next_state = STATE_W'(S_TRAP);
`else
                        w_next_state = STATE_W'(S_FETCH);
                        instrDone    = 1'b1;
`endif
                    end
                endcase
            end
            STATE_W'(S_MEM_ADDR): begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                w_next_state = (opcode == C_OP_LW) ? STATE_W'(S_MEM_RD)
                                                   : STATE_W'(S_MEM_WR);
            end
            STATE_W'(S_MEM_RD): begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    w_next_state = STATE_W'(S_MEM_WB);
                end
            end
            STATE_W'(S_MEM_WB): begin
                regWrite     = 1'b1;
                memToReg     = 1'b1;
                instrDone    = 1'b1;
                w_next_state = STATE_W'(S_FETCH);
            end
            STATE_W'(S_MEM_WR): begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
                if (memReady) begin
                    w_next_state = STATE_W'(S_FETCH);
                end
            end
            STATE_W'(S_EXEC): begin
                aluSrcA      = 1'b1;
                aluOp        = 2'b10;
                w_next_state = STATE_W'(S_R_WB);
            end
            STATE_W'(S_R_WB): begin
                regWrite     = 1'b1;
                regDst       = 1'b1;
                instrDone    = 1'b1;
                w_next_state = STATE_W'(S_FETCH);
            end
            STATE_W'(S_BRANCH): begin
                aluSrcA      = 1'b1;
                aluOp        = 2'b01;
                pcWriteCond  = 1'b1;
                pcSource     = 2'b01;
                instrDone    = 1'b1;
                w_next_state = STATE_W'(S_FETCH);
            end
            STATE_W'(S_JUMP): begin
                pcWrite      = 1'b1;
                pcSource     = 2'b10;
                instrDone    = 1'b1;
                w_next_state = STATE_W'(S_FETCH);
            end
            STATE_W'(S_ADDI_EX): begin
                aluSrcA      = 1'b1;
                aluSrcB      = 2'b10;
                aluOp        = 2'b11;
                w_next_state = STATE_W'(S_ADDI_WB);
            end
            STATE_W'(S_ADDI_WB): begin
                regWrite     = 1'b1;
                instrDone    = 1'b1;
                w_next_state = STATE_W'(S_FETCH);
            end
`ifdef ILLEGAL_OP_TRAP_EN
            STATE_W'(S_TRAP): begin
                illegalOp    = 1'b1;
                w_next_state = STATE_W'(S_TRAP);
            end
`endif
            default: begin
                w_next_state = STATE_W'(S_IDLE);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Function : Directed, table-driven bench for multi_cycle_ctrl, plus
//            hand-written reset, illegal-opcode and latency sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        memReady = 1'b0;
    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        memToReg, regDst, regWrite, aluSrcA, instrDone;
    logic [1:0]  pcSource, aluSrcB, aluOp;
    logic [3:0]  state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegalOp;
`endif

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .pcWriteCond(pcWriteCond),
        .pcSource   (pcSource),
        .iorD       (iorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .memToReg   (memToReg),
        .regDst     (regDst),
        .regWrite   (regWrite),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluOp      (aluOp),
        .instrDone  (instrDone),
        .state      (state)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegalOp  (illegalOp)
`endif
    );

    always #5 clk = ~clk;

    // {pcWrite,pcWriteCond,pcSource,iorD,memRead,memWrite,irWrite,
    //  memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,instrDone}
    logic [16:0] ctl;
    assign ctl = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                  memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, instrDone};

    localparam logic [16:0] C_ZERO    = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [16:0] C_FETCH_W = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
    localparam logic [16:0] C_FETCH_R = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [16:0] C_DEC     = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
    localparam logic [16:0] C_DEC_NOP = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_1;
    localparam logic [16:0] C_MADDR   = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [16:0] C_MEM_RD  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
    localparam logic [16:0] C_MEM_WB  = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_1;
    localparam logic [16:0] C_MEMWR_W = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
    localparam logic [16:0] C_MEMWR_R = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_1;
    localparam logic [16:0] C_EXEC    = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [16:0] C_R_WB    = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_1;
    localparam logic [16:0] C_BRANCH  = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_1;
    localparam logic [16:0] C_JUMP    = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_1;
    localparam logic [16:0] C_ADDI_EX = 17'b0_0_00_0_0_0_0_0_0_0_1_10_11_0;
    localparam logic [16:0] C_ADDI_WB = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_1;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        memReady;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check outputs 1 ns later.
    task automatic step(input string nm, input logic r, input logic [5:0] op,
                        input logic m, input logic [3:0] st, input logic [16:0] c);
        @(negedge clk);
        rst_n    = r;
        opcode   = op;
        memReady = m;
        #1;
        check({nm, " state"}, 32'(state), 32'(st));
        check({nm, " ctl"},   32'(ctl),   32'(c));
`ifdef ILLEGAL_OP_TRAP_EN
        check({nm, " illegalOp"}, 32'(illegalOp), (st == 4'd13) ? 32'd1 : 32'd0);
`endif
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic m,
                       input logic [3:0] st, input logic [16:0] c);
        vec_t v;
        v = '{rst_n: r, opcode: op, memReady: m, exp_state: st, exp_ctl: c};
        vecs.push_back(v);
    endtask

    int lat;

    initial begin
        // Reset, then R-type: 1,2,7,8
        add(0, OP_R, 1, 4'd0, C_ZERO);
        add(0, OP_R, 1, 4'd0, C_ZERO);
        add(0, OP_R, 1, 4'd0, C_ZERO);
        add(1, OP_R, 1, 4'd0, C_ZERO);
        add(1, OP_R, 1, 4'd1, C_FETCH_R);
        add(1, OP_R, 1, 4'd2, C_DEC);
        add(1, OP_R, 1, 4'd7, C_EXEC);
        add(1, OP_R, 1, 4'd8, C_R_WB);
        // lw with 2 fetch waits and 3 read waits: done 10 cycles after FETCH entry
        add(1, OP_LW, 0, 4'd1, C_FETCH_W);
        add(1, OP_LW, 0, 4'd1, C_FETCH_W);
        add(1, OP_LW, 1, 4'd1, C_FETCH_R);
        add(1, OP_LW, 0, 4'd2, C_DEC);
        add(1, OP_LW, 0, 4'd3, C_MADDR);
        add(1, OP_LW, 0, 4'd4, C_MEM_RD);
        add(1, OP_LW, 0, 4'd4, C_MEM_RD);
        add(1, OP_LW, 0, 4'd4, C_MEM_RD);
        add(1, OP_LW, 1, 4'd4, C_MEM_RD);
        add(1, OP_LW, 0, 4'd5, C_MEM_WB);
        // sw (memReady ignored in DECODE)
        add(1, OP_SW, 1, 4'd1, C_FETCH_R);
        add(1, OP_SW, 0, 4'd2, C_DEC);
        add(1, OP_SW, 1, 4'd3, C_MADDR);
        add(1, OP_SW, 1, 4'd6, C_MEMWR_R);
        // beq
        add(1, OP_BEQ, 1, 4'd1, C_FETCH_R);
        add(1, OP_BEQ, 1, 4'd2, C_DEC);
        add(1, OP_BEQ, 0, 4'd9, C_BRANCH);
        // j
        add(1, OP_J, 1, 4'd1, C_FETCH_R);
        add(1, OP_J, 1, 4'd2, C_DEC);
        add(1, OP_J, 1, 4'd10, C_JUMP);
        // addi
        add(1, OP_ADDI, 1, 4'd1, C_FETCH_R);
        add(1, OP_ADDI, 1, 4'd2, C_DEC);
        add(1, OP_ADDI, 1, 4'd11, C_ADDI_EX);
        add(1, OP_ADDI, 1, 4'd12, C_ADDI_WB);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].opcode,
                 vecs[i].memReady, vecs[i].exp_state, vecs[i].exp_ctl);
        end

        // Illegal opcode
        step("bad fetch", 1, OP_BAD, 1, 4'd1, C_FETCH_R);
`ifdef ILLEGAL_OP_TRAP_EN
        step("bad decode", 1, OP_BAD, 1, 4'd2, C_DEC);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("trap%0d", i), 1, OP_BAD, 1'(i), 4'd13, C_ZERO);
        end
        step("trap reset", 0, OP_BAD, 1, 4'd0, C_ZERO);
`else
        step("nop decode", 1, OP_BAD, 1, 4'd2, C_DEC_NOP);
        step("nop refetch", 1, OP_R, 1, 4'd1, C_FETCH_R);
        step("pre reset", 0, OP_R, 1, 4'd0, C_ZERO);
`endif

        // Reset in the middle of a waiting store
        step("sw2 idle", 1, OP_SW, 1, 4'd0, C_ZERO);
        step("sw2 fetch", 1, OP_SW, 1, 4'd1, C_FETCH_R);
        step("sw2 decode", 1, OP_SW, 1, 4'd2, C_DEC);
        step("sw2 maddr", 1, OP_SW, 0, 4'd3, C_MADDR);
        step("sw2 wait0", 1, OP_SW, 0, 4'd6, C_MEMWR_W);
        step("sw2 wait1", 1, OP_SW, 0, 4'd6, C_MEMWR_W);
        @(posedge clk);
        #2;
        check("sw2 pre-reset memWrite", 32'(memWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async memWrite", 32'(memWrite), 32'd0);
        check("async state", 32'(state), 32'd0);
        check("async ctl", 32'(ctl), 32'(C_ZERO));
        step("post reset hold", 0, OP_LW, 1, 4'd0, C_ZERO);
        step("post release idle", 1, OP_LW, 1, 4'd0, C_ZERO);

        // Zero-wait lw latency from FETCH entry to instrDone, inclusive
        step("lat fetch", 1, OP_LW, 1, 4'd1, C_FETCH_R);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            lat++;
            if (instrDone) break;
        end
        check("lw latency", 32'(lat), 32'd5);
        step("lat refetch", 1, OP_LW, 1, 4'd1, C_FETCH_R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
